// File: rtl/mio_wait_ctrl_pkg.sv
// mio_wait_ctrl_pkg: region codes, base nibbles and FSM states shared by the MIO sequencer
package mio_wait_ctrl_pkg;
    localparam logic [1:0] REG_RAM   = 2'd0;
    localparam logic [1:0] REG_IO    = 2'd1;
    localparam logic [1:0] REG_UNMAP = 2'd2;
    localparam logic [3:0] RAM_NIB    = 4'h0;
    localparam logic [3:0] IO_NIB_LO  = 4'hE;
    localparam logic [3:0] IO_NIB_HI  = 4'hF;
    typedef enum logic [1:0] {S_IDLE, S_RAM_ACC, S_IO_ACC, S_RESP} state_e;
endpackage

// File: rtl/mio_region_dec.sv
// mio_region_dec: maps the top address nibble to a RAM / IO / unmapped region code
module mio_region_dec
    import mio_wait_ctrl_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [1:0] region_o
);
    assign region_o = (nib_i == RAM_NIB) ? REG_RAM :
                      (nib_i == IO_NIB_LO || nib_i == IO_NIB_HI) ? REG_IO : REG_UNMAP;
endmodule

// File: rtl/mio_wait_ctrl.sv
// mio_wait_ctrl: CPU bus sequencer inserting RAM/IO wait states and a one-cycle ready pulse
module mio_wait_ctrl
    import mio_wait_ctrl_pkg::*;
#(
    parameter int RAM_LAT = 2,
    parameter int RAM_AW  = 10,
    parameter int IO_LAT  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_mio,
    input  logic              mem_w,
    input  logic [31:0]       addr_bus,
    input  logic [31:0]       cpu_data2bus,
    output logic              mio_ready,
    output logic [31:0]       cpu_data4bus,
    output logic [RAM_AW-1:0] ram_addr,
    output logic              ram_we,
    output logic [31:0]       ram_data_in,
    input  logic [31:0]       ram_data_out,
    output logic [31:0]       io_addr,
    output logic              io_we,
    output logic [31:0]       io_data_out,
    input  logic [31:0]       io_data_in,
    output logic              bus_err,
    output logic [31:0]       wait_cnt
);
    localparam logic [2:0] RAM_LAST = 3'(RAM_LAT - 1);
    localparam logic [2:0] IO_LAST  = 3'(IO_LAT - 1);
    state_e      state_q, state_d;
    logic [1:0]  region;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d, wait_q, wait_d;
    logic        we_q, we_d, first_q, first_d, err_q, err_d;
    logic [2:0]  lat_q, lat_d;

    mio_region_dec u_dec (
        .nib_i    (addr_bus[31:28]),
        .region_o (region)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            wait_q  <= '0;
            we_q    <= 1'b0;
            first_q <= 1'b0;
            err_q   <= 1'b0;
            lat_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            wait_q  <= wait_d;
            we_q    <= we_d;
            first_q <= first_d;
            err_q   <= err_d;
            lat_q   <= lat_d;
        end
    end

    // lat_q counts down to 0; the access state ends (and reads capture) when it reaches 0
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        wait_d  = wait_q;
        we_d    = we_q;
        first_d = 1'b0;
        err_d   = err_q;
        lat_d   = lat_q;
        case (state_q)
            S_IDLE: if (cpu_mio) begin
                addr_d  = addr_bus;
                wdata_d = cpu_data2bus;
                we_d    = mem_w;
                first_d = 1'b1;
                lat_d   = mem_w ? 3'd0 : (region == REG_RAM) ? RAM_LAST : IO_LAST;
                state_d = (region == REG_RAM) ? S_RAM_ACC : (region == REG_IO) ? S_IO_ACC : S_RESP;
                if (region == REG_UNMAP) begin
                    err_d   = 1'b1;
                    rdata_d = mem_w ? rdata_q : '0;
                end
            end
            S_RAM_ACC, S_IO_ACC: begin
                wait_d = (!first_q && wait_q != '1) ? wait_q + 32'd1 : wait_q;
                if (lat_q == 3'd0) begin
                    state_d = S_RESP;
                    rdata_d = we_q ? rdata_q : (state_q == S_RAM_ACC) ? ram_data_out : io_data_in;
                end else begin
                    lat_d = lat_q - 3'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign mio_ready    = state_q == S_RESP;
    assign ram_we       = state_q == S_RAM_ACC && we_q;
    assign io_we        = state_q == S_IO_ACC && we_q;
    assign ram_addr     = addr_q[RAM_AW+1:2];
    assign ram_data_in  = wdata_q;
    assign io_addr      = addr_q;
    assign io_data_out  = wdata_q;
    assign cpu_data4bus = rdata_q;
    assign bus_err      = err_q;
    assign wait_cnt     = wait_q;
endmodule

// File: tb/tb_mio_wait_ctrl.sv
// tb_mio_wait_ctrl: scoreboard bench for mio_wait_ctrl with a one-register-stage RAM model
module tb_mio_wait_ctrl;
    logic        clk = 1'b0, rst = 1'b1;
    logic        cpu_mio = 1'b0, mem_w = 1'b0;
    logic [31:0] addr_bus = '0, cpu_data2bus = '0;
    logic        mio_ready, ram_we, io_we, bus_err;
    logic [31:0] cpu_data4bus, ram_data_in, io_addr, io_data_out, wait_cnt;
    logic [9:0]  ram_addr;
    logic [31:0] ram_data_out = '0, io_data_in = 32'h55;
    logic [31:0] mem [0:1023];
    int          cyc = 0, cmp = 0, fails = 0;
    int          ram_we_n = 0, io_we_n = 0;
    logic [9:0]  ram_a_seen;
    logic [31:0] ram_d_seen, io_d_seen;

    typedef struct {
        int          cyc;
        logic [31:0] data;
        logic [31:0] wcnt;
        logic        err;
    } exp_t;
    exp_t exp_q[$];

    mio_wait_ctrl #(.RAM_LAT(2), .RAM_AW(10), .IO_LAT(1)) dut (
        .clk          (clk),
        .rst          (rst),
        .cpu_mio      (cpu_mio),
        .mem_w        (mem_w),
        .addr_bus     (addr_bus),
        .cpu_data2bus (cpu_data2bus),
        .mio_ready    (mio_ready),
        .cpu_data4bus (cpu_data4bus),
        .ram_addr     (ram_addr),
        .ram_we       (ram_we),
        .ram_data_in  (ram_data_in),
        .ram_data_out (ram_data_out),
        .io_addr      (io_addr),
        .io_we        (io_we),
        .io_data_out  (io_data_out),
        .io_data_in   (io_data_in),
        .bus_err      (bus_err),
        .wait_cnt     (wait_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ram_we) mem[ram_addr] <= ram_data_in;
        ram_data_out <= mem[ram_addr];
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    always @(negedge clk) begin
        if (ram_we) begin
            ram_we_n++;
            ram_a_seen = ram_addr;
            ram_d_seen = ram_data_in;
        end
        if (io_we) begin
            io_we_n++;
            io_d_seen = io_data_out;
        end
        if (ram_we && io_we) chk("dual_strobe", 32'd1, 32'd0);
    end

    always @(negedge clk) begin
        if (mio_ready) begin
            if (exp_q.size() == 0) begin
                chk("spurious_ready", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("ready_cycle", cyc, e.cyc);
                chk("rdata", cpu_data4bus, e.data);
                chk("wait_cnt", wait_cnt, e.wcnt);
                chk("bus_err", {31'd0, bus_err}, {31'd0, e.err});
            end
        end
    end

    task automatic wait_ready();
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (mio_ready) return;
        end
        cmp++;
        fails++;
        $display("FAIL ready_timeout: no mio_ready within 20 cycles (cycle %0d)", cyc);
    endtask

    task automatic req(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] exp_d, input int lat, input logic [31:0] exp_w,
                       input logic exp_e);
        @(negedge clk);
        cpu_mio      = 1'b1;
        mem_w        = w;
        addr_bus     = a;
        cpu_data2bus = d;
        ram_we_n     = 0;
        io_we_n      = 0;
        exp_q.push_back('{cyc + lat, exp_d, exp_w, exp_e});
        wait_ready();
        cpu_mio = 1'b0;
        #1;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[0] = 32'h1111_0000;
        mem[1] = 32'h2222_0001;
        mem[2] = 32'h3333_0002;
        mem[4] = 32'hDEAD_BEEF;
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, mio_ready}, 32'd0);
        chk("rst_ram_we", {31'd0, ram_we}, 32'd0);
        chk("rst_io_we", {31'd0, io_we}, 32'd0);
        chk("rst_bus_err", {31'd0, bus_err}, 32'd0);
        chk("rst_wait_cnt", wait_cnt, 32'd0);
        chk("rst_rdata", cpu_data4bus, 32'd0);
        rst = 1'b0;

        req(1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 3, 32'd1, 1'b0);
        chk("ram_addr_rd", {22'd0, ram_addr}, 32'd4);

        req(1'b1, 32'h0000_0FFC, 32'h1234_5678, 32'hDEAD_BEEF, 2, 32'd1, 1'b0);
        chk("ram_we_cycles", ram_we_n, 32'd1);
        chk("ram_we_addr", {22'd0, ram_a_seen}, 32'h3FF);
        chk("ram_we_data", ram_d_seen, 32'h1234_5678);
        chk("ram_wr_no_io_we", io_we_n, 32'd0);

        req(1'b1, 32'hE000_0000, 32'h0000_00A5, 32'hDEAD_BEEF, 2, 32'd1, 1'b0);
        chk("io_we_cycles", io_we_n, 32'd1);
        chk("io_we_data", io_d_seen, 32'h0000_00A5);
        chk("io_wr_no_ram_we", ram_we_n, 32'd0);

        req(1'b0, 32'hF000_0000, 32'h0, 32'h0000_0055, 2, 32'd1, 1'b0);

        req(1'b0, 32'h8000_0000, 32'h0, 32'h0, 1, 32'd1, 1'b1);

        req(1'b0, 32'h0000_0FFC, 32'h0, 32'h1234_5678, 3, 32'd2, 1'b1);

        @(negedge clk);
        cpu_mio  = 1'b1;
        mem_w    = 1'b0;
        addr_bus = 32'h0000_0000;
        exp_q.push_back('{cyc + 3, 32'h1111_0000, 32'd3, 1'b1});
        wait_ready();
        addr_bus = 32'h0000_0004;
        exp_q.push_back('{cyc + 4, 32'h2222_0001, 32'd4, 1'b1});
        wait_ready();
        cpu_mio = 1'b0;

        @(negedge clk);
        cpu_mio  = 1'b1;
        mem_w    = 1'b0;
        addr_bus = 32'h0000_0008;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_ready", {31'd0, mio_ready}, 32'd0);
        chk("abort_ram_we", {31'd0, ram_we}, 32'd0);
        chk("abort_bus_err", {31'd0, bus_err}, 32'd0);
        chk("abort_wait_cnt", wait_cnt, 32'd0);
        chk("abort_rdata", cpu_data4bus, 32'd0);
        chk("abort_ram_addr", {22'd0, ram_addr}, 32'd0);
        cpu_mio = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        req(1'b0, 32'h0000_0004, 32'h0, 32'h2222_0001, 3, 32'd1, 1'b0);

        req(1'b1, 32'h1000_0000, 32'hCAFE_F00D, 32'h2222_0001, 1, 32'd1, 1'b1);
        chk("unmap_wr_ram_we", ram_we_n, 32'd0);
        chk("unmap_wr_io_we", io_we_n, 32'd0);

        repeat (3) @(negedge clk);
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, fails);
        $finish;
    end
endmodule

// File: doc/mio_wait_ctrl.md
Name: mio_wait_ctrl

Overview:
- Memory/IO request sequencer between the multi-cycle CPU's bus port and the RAM block / peripheral bus.
- Replaces the constant-high MIO_ready tie-off with a real handshake, so synchronous block RAM with read latency is served correctly.
- Decodes each CPU request into a RAM, IO or unmapped access.
- Inserts the required wait states, then returns read data with a one-cycle ready pulse.

Parameters:
- RAM_LAT, 2, cycles from RAM address presentation to valid ram_data_out (1..7).
- RAM_AW, 10, RAM word-address width (word address = addr_bus[RAM_AW+1:2]).
- IO_LAT, 1, cycles an IO read is held before capture (1..7).

Ports:
- clk  in  1  system clock (rising edge)
- rst  in  1  asynchronous, active-high reset
- cpu_mio  in  1  CPU request valid (level)
- mem_w  in  1  1 = write, 0 = read; sampled with cpu_mio
- addr_bus  in  32  byte address
- cpu_data2bus  in  32  CPU write data
- mio_ready  out  1  one-cycle completion pulse
- cpu_data4bus  out  32  read data to CPU, valid when mio_ready=1 and held until next completion
- ram_addr  out  RAM_AW  RAM word address
- ram_we  out  1  RAM write strobe
- ram_data_in  out  32  RAM write data
- ram_data_out  in  32  RAM read data
- io_addr  out  32  peripheral address
- io_we  out  1  peripheral write strobe
- io_data_out  out  32  peripheral write data
- io_data_in  in  32  peripheral read data
- bus_err  out  1  sticky unmapped-access flag
- wait_cnt  out  32  total inserted wait cycles, saturating

Behaviour:
- Reset values: state IDLE; mio_ready=0; ram_we=0; io_we=0; bus_err=0; wait_cnt=0. All address and data registers are 0.
- Decode on addr_bus[31:28]:
  - 0x0 → RAM
  - 0xE or 0xF → IO
  - anything else → UNMAPPED
- States: IDLE, RAM_ACC, IO_ACC, RESP.
- IDLE:
  - When cpu_mio=1, latch addr_bus, cpu_data2bus, mem_w and region; load lat_cnt.
  - Next state: RAM_ACC, IO_ACC, or RESP (UNMAPPED).
  - When cpu_mio=0, stay in IDLE.
- RAM_ACC:
  - ram_addr and ram_data_in are driven from the latched registers for the whole state.
  - Write: ram_we=1 for exactly the first RAM_ACC cycle, then go to RESP (1 cycle in RAM_ACC).
  - Read: stay RAM_LAT cycles; capture ram_data_out into cpu_data4bus on the last cycle; go to RESP.
- IO_ACC:
  - Write: io_we=1 for one cycle, then go to RESP.
  - Read: hold IO_LAT cycles, capture io_data_in, then go to RESP.
- RESP:
  - mio_ready=1 for exactly one cycle, then go to IDLE.
  - UNMAPPED read returns cpu_data4bus=0. UNMAPPED write produces no strobes.
  - Both UNMAPPED cases set bus_err=1. bus_err is cleared only by rst.
- Latency, counted from the cycle cpu_mio is first seen in IDLE to the mio_ready cycle:
  - RAM read: RAM_LAT+1
  - RAM write: 2
  - IO read: IO_LAT+1
  - IO write: 2
  - UNMAPPED: 1
- Requester contract:
  - cpu_mio and its qualifiers are stable from assertion until the mio_ready edge.
  - Changes while busy are ignored, because latched copies are used.
  - A request still asserted in the cycle after RESP is treated as a new transaction (back-to-back, no bubble beyond IDLE).
- wait_cnt increments by 1 in every RAM_ACC/IO_ACC cycle except the first; saturates at 0xFFFFFFFF.
- Register-to-output: ram_we and io_we are never asserted outside their access state; never both set in the same cycle.
- rst asserted mid-transaction:
  - Aborts immediately to IDLE; strobes drop asynchronously.
  - No mio_ready is issued for the aborted request.
- lat_cnt is 3 bits; RAM_LAT=1 means capture on the first RAM_ACC cycle.

Decomposition:
- Shared package: region encoding constants, state encoding, region base nibbles (4'h0, 4'hE, 4'hF).
- One sub-module, mio_region_dec: combinational addr_bus[31:28] → region code. The rest stays in the top FSM.

Test Plan:
- RAM read, RAM_LAT=2, addr 0x0000_0010, ram_data_out=0xDEAD_BEEF at word 4 → ram_addr=4; mio_ready pulses 3 cycles after request; cpu_data4bus=0xDEADBEEF; wait_cnt=1.
- RAM write, addr 0x0000_0FFC, data 0x1234_5678 → ram_we high exactly 1 cycle with ram_addr=0x3FF, ram_data_in=0x12345678; mio_ready 2 cycles after request.
- IO write, addr 0xE000_0000, data 0xA5 → io_we 1 cycle with io_data_out=0xA5; no ram_we; IO read at 0xF000_0000 with io_data_in=0x55 → cpu_data4bus=0x55.
- UNMAPPED read, addr 0x8000_0000 → mio_ready next cycle, cpu_data4bus=0, bus_err=1 and stays 1 through subsequent valid accesses.
- Back-to-back: cpu_mio held high across two RAM reads (addresses 0x0, 0x4) → two separate ready pulses 4 cycles apart; second read returns word 1.
- rst asserted during RAM_ACC of a read → state IDLE, mio_ready never pulses, outputs at reset values; next request completes normally.
